// File: rtl/frankie_mon_pkg.sv
// frankie_mon_pkg: shared state encoding and checkpoint entry layout for the Frankie run monitor
package frankie_mon_pkg;
   localparam int MON_DATA_W = 16;
   localparam int MON_REG_AW = 3;
   localparam int MON_CYC_W  = 16;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
   typedef struct packed {
      logic [MON_CYC_W-1:0]  cycle;
      logic [MON_REG_AW-1:0] reg_idx;
      logic [MON_DATA_W-1:0] value;
   } entry_t;
endpackage

// File: rtl/frankie_shadow_regs.sv
// frankie_shadow_regs: shadow register file with write-to-read forwarding
module frankie_shadow_regs #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [REG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [REG_AW-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);
   localparam int N = 2 ** REG_AW;
   logic [DATA_W-1:0] regs_q [N];
   logic [DATA_W-1:0] regs_d [N];
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end
   // a write landing in the checked cycle must be visible to the check
   assign rd_data = (wr_en && wr_addr == rd_addr) ? wr_data : regs_q[rd_addr];
endmodule

// File: rtl/frankie_checkpoint_monitor.sv
// frankie_checkpoint_monitor: shadows core writebacks and checks a cycle-indexed checkpoint table
module frankie_checkpoint_monitor
   import frankie_mon_pkg::*;
#(
   parameter int DATA_W     = MON_DATA_W,
   parameter int REG_AW     = MON_REG_AW,
   parameter int NUM_CHECKS = 16,
   parameter int CYC_W      = MON_CYC_W,
   parameter int MAX_CYCLES = 4096
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            cfg_wr,
   input  logic [$clog2(NUM_CHECKS)-1:0]   cfg_idx,
   input  logic [CYC_W-1:0]                cfg_cycle,
   input  logic [REG_AW-1:0]               cfg_reg,
   input  logic [DATA_W-1:0]               cfg_value,
   input  logic [$clog2(NUM_CHECKS):0]     cfg_count,
   input  logic                            start,
   input  logic                            wb_en,
   input  logic [REG_AW-1:0]               wb_addr,
   input  logic [DATA_W-1:0]               wb_data,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic                            timeout,
   output logic [$clog2(NUM_CHECKS)-1:0]   fail_idx,
   output logic [DATA_W-1:0]               fail_value,
   output logic [CYC_W-1:0]                cycle_count
);
   localparam int IW = $clog2(NUM_CHECKS);
   localparam int CW = IW + 1;
   localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
   state_e            state_q, state_d;
   logic [CYC_W-1:0]  cycle_q, cycle_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [IW-1:0]     fail_idx_q, fail_idx_d;
   logic [DATA_W-1:0] fail_value_q, fail_value_d;
   entry_t            table_q [NUM_CHECKS];
   entry_t            entry_d;
   entry_t            cur;
   logic              table_we;
   logic [DATA_W-1:0] fwd;
   logic              due, match, last;
   assign entry_d  = '{cycle: cfg_cycle, reg_idx: cfg_reg, value: cfg_value};
   assign table_we = cfg_wr && state_q == ST_IDLE;
   assign cur      = table_q[ptr_q];
   // entries behind the counter are checked as soon as they become current
   assign due      = cur.cycle <= cycle_q;
   assign match    = fwd == cur.value;
   assign last     = (CW'(ptr_q) + CW'(1)) == count_q;
   frankie_shadow_regs #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_shadow (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wb_en),
      .wr_addr (wb_addr),
      .wr_data (wb_data),
      .rd_addr (cur.reg_idx),
      .rd_data (fwd)
   );
   always_comb begin
      state_d      = state_q;
      cycle_d      = cycle_q;
      ptr_d        = ptr_q;
      count_d      = count_q;
      done_d       = done_q;
      pass_d       = pass_q;
      timeout_d    = timeout_q;
      fail_idx_d   = fail_idx_q;
      fail_value_d = fail_value_q;
      if (state_q != ST_RUN) begin
         if (start) begin
            state_d      = ST_RUN;
            cycle_d      = '0;
            ptr_d        = '0;
            count_d      = cfg_count;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
            fail_idx_d   = '0;
            fail_value_d = '0;
         end
      end else begin
         // timeout outranks any checkpoint decided in the same cycle
         if (count_q == '0) {done_d, pass_d} = 2'b11;
         else if (cycle_q >= MAX_C) {done_d, timeout_d} = 2'b11;
         else if (due && !match) begin
            done_d       = 1'b1;
            fail_idx_d   = ptr_q;
            fail_value_d = fwd;
         end
         else if (due && last) {done_d, pass_d} = 2'b11;
         else if (due) ptr_d = ptr_q + 1'b1;
         if (done_d) state_d = ST_DONE;
         else cycle_d = cycle_q + 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cycle_q      <= '0;
         ptr_q        <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         fail_idx_q   <= '0;
         fail_value_q <= '0;
      end else begin
         state_q      <= state_d;
         cycle_q      <= cycle_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         timeout_q    <= timeout_d;
         fail_idx_q   <= fail_idx_d;
         fail_value_q <= fail_value_d;
      end
   end
   always_ff @(posedge clock) begin
      if (table_we) table_q[cfg_idx] <= entry_d;
   end
   assign busy        = state_q == ST_RUN;
   assign done        = done_q;
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign fail_idx    = fail_idx_q;
   assign fail_value  = fail_value_q;
   assign cycle_count = cycle_q;
endmodule

// File: tb/tb_frankie_checkpoint_monitor.sv
// tb_frankie_checkpoint_monitor: directed program runs with hand-computed verdicts
module tb_frankie_checkpoint_monitor;
   localparam logic [2:0] MARY = 3'd1;
   localparam logic [2:0] SHELLEY = 3'd2;
   localparam logic [2:0] SP = 3'd7;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [3:0]  cfg_idx = '0;
   logic [15:0] cfg_cycle = '0;
   logic [2:0]  cfg_reg = '0;
   logic [15:0] cfg_value = '0;
   logic [4:0]  cfg_count = '0;
   logic        start = 1'b0;
   logic        wb_en = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [15:0] wb_data = '0;
   logic        busy, done, pass, timeout;
   logic [3:0]  fail_idx;
   logic [15:0] fail_value, cycle_count;
   int          tests = 0;
   int          fails = 0;
   int          prog_cyc [8];
   logic [2:0]  prog_reg [8];
   logic [15:0] prog_val [8];
   int          prog_n = 0;
   int          vcyc;
   logic        busy0, done0;

   frankie_checkpoint_monitor dut (
      .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx),
      .cfg_cycle(cfg_cycle), .cfg_reg(cfg_reg), .cfg_value(cfg_value),
      .cfg_count(cfg_count), .start(start), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
      .fail_idx(fail_idx), .fail_value(fail_value), .cycle_count(cycle_count)
   );

   always #5 clock = ~clock;

   task automatic apply_reset();
      @(negedge clock); reset = 1'b0;
      @(negedge clock); reset = 1'b1;
   endtask

   task automatic cfg(input int idx, input int cyc, input logic [2:0] r, input logic [15:0] v);
      @(negedge clock);
      cfg_wr = 1'b1; cfg_idx = 4'(idx); cfg_cycle = 16'(cyc); cfg_reg = r; cfg_value = v;
      @(negedge clock);
      cfg_wr = 1'b0;
   endtask

   task automatic set_add_prog();
      prog_n = 4;
      prog_cyc[0] = 1;  prog_reg[0] = MARY;    prog_val[0] = 16'd2;
      prog_cyc[1] = 5;  prog_reg[1] = MARY;    prog_val[1] = 16'd7;
      prog_cyc[2] = 8;  prog_reg[2] = SHELLEY; prog_val[2] = 16'd5;
      prog_cyc[3] = 12; prog_reg[3] = MARY;    prog_val[3] = 16'd12;
   endtask

   task automatic drive_wb(input int c);
      wb_en = 1'b0;
      for (int k = 0; k < prog_n; k++)
         if (prog_cyc[k] == c) begin wb_en = 1'b1; wb_addr = prog_reg[k]; wb_data = prog_val[k]; end
   endtask

   // vcyc is the run cycle whose comparison produced the verdict, -1 if budget ran out
   task automatic run_prog(input int cnt, input int budget);
      @(negedge clock); start = 1'b1; cfg_count = 5'(cnt);
      @(negedge clock); start = 1'b0;
      busy0 = busy; done0 = done;
      vcyc = -1;
      for (int c = 0; c < budget; c++) begin
         drive_wb(c);
         @(negedge clock);
         if (done) begin vcyc = c; break; end
      end
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      tests++;
      if ({busy, done, pass, timeout, fail_idx, fail_value, cycle_count} !== '0) begin
         fails++; $display("FAIL reset_outputs: got busy=%0b done=%0b pass=%0b to=%0b fi=%0d fv=%0d cc=%0d want all 0", busy, done, pass, timeout, fail_idx, fail_value, cycle_count);
      end
   endtask

   task automatic test_add_pass();
      set_add_prog();
      cfg(0, 2, MARY, 16'd2); cfg(1, 6, MARY, 16'd7); cfg(2, 9, SHELLEY, 16'd5); cfg(3, 13, MARY, 16'd12);
      run_prog(4, 40);
      tests++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin fails++; $display("FAIL add_busy: got busy=%0b done=%0b want 1 0", busy0, done0); end
      tests++; if (vcyc !== 13) begin fails++; $display("FAIL add_verdict_cycle: got %0d want 13", vcyc); end
      tests++; if (pass !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL add_pass: got pass=%0b to=%0b busy=%0b want 1 0 0", pass, timeout, busy); end
      tests++; if (cycle_count !== 16'd13) begin fails++; $display("FAIL add_cycle_count: got %0d want 13", cycle_count); end
   endtask

   task automatic test_add_fail();
      apply_reset();
      set_add_prog();
      cfg(3, 13, MARY, 16'd13);
      run_prog(4, 40);
      tests++; if (vcyc !== 13) begin fails++; $display("FAIL fail_verdict_cycle: got %0d want 13", vcyc); end
      tests++; if (pass !== 1'b0 || timeout !== 1'b0) begin fails++; $display("FAIL fail_flags: got pass=%0b to=%0b want 0 0", pass, timeout); end
      tests++; if (fail_idx !== 4'd3 || fail_value !== 16'd12) begin fails++; $display("FAIL fail_latch: got idx=%0d val=%0d want 3 12", fail_idx, fail_value); end
      tests++; if (cycle_count !== 16'd13) begin fails++; $display("FAIL fail_cycle_count: got %0d want 13", cycle_count); end
   endtask

   task automatic test_forward();
      apply_reset();
      prog_n = 1; prog_cyc[0] = 4; prog_reg[0] = MARY; prog_val[0] = 16'h7FFF;
      cfg(0, 4, MARY, 16'h7FFF);
      run_prog(1, 20);
      tests++; if (vcyc !== 4 || pass !== 1'b1) begin fails++; $display("FAIL forward: got vcyc=%0d pass=%0b want 4 1", vcyc, pass); end
   endtask

   task automatic test_catchup();
      apply_reset();
      prog_n = 1; prog_cyc[0] = 1; prog_reg[0] = MARY; prog_val[0] = 16'd10;
      cfg(0, 3, MARY, 16'd10); cfg(1, 3, SP, 16'd0);
      run_prog(2, 20);
      tests++; if (vcyc !== 4 || pass !== 1'b1) begin fails++; $display("FAIL catchup: got vcyc=%0d pass=%0b want 4 1", vcyc, pass); end
      tests++; if (cycle_count !== 16'd4) begin fails++; $display("FAIL catchup_cycle_count: got %0d want 4", cycle_count); end
   endtask

   task automatic test_timeout();
      apply_reset();
      prog_n = 0;
      cfg(0, 5000, MARY, 16'd0);
      run_prog(1, 5000);
      tests++; if (vcyc !== 4096) begin fails++; $display("FAIL timeout_cycle: got %0d want 4096", vcyc); end
      tests++; if (timeout !== 1'b1 || pass !== 1'b0) begin fails++; $display("FAIL timeout_flags: got to=%0b pass=%0b want 1 0", timeout, pass); end
      tests++; if (cycle_count !== 16'd4096) begin fails++; $display("FAIL timeout_cycle_count: got %0d want 4096", cycle_count); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      set_add_prog();
      cfg(0, 2, MARY, 16'd2); cfg(1, 6, MARY, 16'd7); cfg(2, 9, SHELLEY, 16'd5); cfg(3, 13, MARY, 16'd12);
      @(negedge clock); start = 1'b1; cfg_count = 5'd4;
      @(negedge clock); start = 1'b0;
      for (int c = 0; c < 7; c++) begin drive_wb(c); @(negedge clock); end
      wb_en = 1'b0; reset = 1'b0;
      @(negedge clock); reset = 1'b1;
      tests++;
      if ({busy, done, pass, timeout, fail_idx, fail_value, cycle_count} !== '0) begin
         fails++; $display("FAIL mid_reset_outputs: got busy=%0b done=%0b pass=%0b to=%0b cc=%0d want all 0", busy, done, pass, timeout, cycle_count);
      end
      prog_n = 0;
      cfg(0, 0, MARY, 16'd0);
      run_prog(1, 20);
      tests++; if (vcyc !== 0 || pass !== 1'b1) begin fails++; $display("FAIL mid_reset_rerun: got vcyc=%0d pass=%0b fv=%0d want 0 1", vcyc, pass, fail_value); end
   endtask

   task automatic test_empty_and_ignore();
      prog_n = 0;
      run_prog(0, 20);
      tests++; if (vcyc !== 0 || pass !== 1'b1 || cycle_count !== 16'd0) begin fails++; $display("FAIL empty_table: got vcyc=%0d pass=%0b cc=%0d want 0 1 0", vcyc, pass, cycle_count); end
      cfg(0, 0, MARY, 16'h1234);
      run_prog(1, 20);
      tests++; if (vcyc !== 0 || pass !== 1'b1) begin fails++; $display("FAIL cfg_in_done_ignored: got vcyc=%0d pass=%0b fv=%0h want 0 1", vcyc, pass, fail_value); end
   endtask

   initial begin
      test_reset();
      test_add_pass();
      test_add_fail();
      test_forward();
      test_catchup();
      test_timeout();
      test_mid_reset();
      test_empty_and_ignore();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/frankie_checkpoint_monitor.md
# frankie_checkpoint_monitor

Synthesizable run monitor that sits beside the Frankie multicycle core, in simulation and on the FPGA. It snoops the register-file writeback port and keeps a shadow copy of every architectural register. After a start pulse it counts clock cycles and compares a programmed table of (cycle, register, expected value) checkpoints. It reports pass, first failure or timeout, so directed program runs (add, sub, big immediate, stack, load/store, function call, swap, summation) check themselves with no manual waveform inspection.

## Interface
- DATA_W, 16: register and expected-value width
- REG_AW, 3: register index width; shadow file holds 2**REG_AW registers
- NUM_CHECKS, 16: checkpoint table depth
- CYC_W, 16: cycle counter and checkpoint cycle width
- MAX_CYCLES, 4096: timeout bound; must be < 2**CYC_W

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; clears all state
- cfg_wr  in  1  write one checkpoint entry (accepted only in IDLE)
- cfg_idx  in  $clog2(NUM_CHECKS)  entry index
- cfg_cycle  in  CYC_W  cycle offset from start at which to check
- cfg_reg  in  REG_AW  register to check
- cfg_value  in  DATA_W  expected value
- cfg_count  in  $clog2(NUM_CHECKS)+1  number of valid entries, sampled on start
- start  in  1  begin run (accepted only in IDLE)
- wb_en  in  1  core register write strobe
- wb_addr  in  REG_AW  core write index
- wb_data  in  DATA_W  core write data
- busy  out  1  high in RUN
- done  out  1  high in DONE; cleared by the next accepted start
- pass  out  1  valid when done: every entry matched
- timeout  out  1  valid when done: MAX_CYCLES reached with entries pending
- fail_idx  out  $clog2(NUM_CHECKS)  first mismatching entry
- fail_value  out  DATA_W  shadow value seen at that mismatch
- cycle_count  out  CYC_W  cycles elapsed in the current or last run

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE; all outputs 0, shadow registers 0, table contents undefined.
- IDLE: cfg_wr writes table[cfg_idx]. start latches cfg_count, sets ptr=0, cycle_count=0, clears done/pass/timeout/fail_*, and moves to RUN. If cfg_count==0, it moves to DONE with pass=1 on the next edge.
- Shadow file: updated on every wb_en in every state, so register state carried across runs stays in step with the core. Writes to index 0 are stored like any other write.
- RUN: each cycle, if cycle_count == table[ptr].cycle, compare forwarded value = (wb_en && wb_addr==reg) ? wb_data : shadow[reg]. This means a write in the checkpoint cycle is visible to the check.
  - Match: ptr++. If ptr was cfg_count-1, go to DONE with pass=1.
  - Mismatch: latch fail_idx=ptr and fail_value, go to DONE with pass=0.
- Entries must be in non-decreasing cycle order. An entry whose cycle is already below cycle_count is checked in the cycle it becomes current (catch-up). At most one entry is checked per cycle.
- Timeout: if cycle_count reaches MAX_CYCLES in RUN without completion, go to DONE with timeout=1 and pass=0. A checkpoint that matches in that same cycle does not complete the run.
- DONE: outputs hold. start returns to RUN, using the same start rules as IDLE. cfg_wr is ignored in both RUN and DONE.
- start or cfg_wr during RUN: ignored.

## Timing
- cycle_count is 0 in the first RUN cycle and increments every RUN cycle; it freezes in DONE.
- Verdict latency: done rises on the edge after the deciding comparison cycle.
- Reset mid-run: the next edge with reset low returns the block to IDLE, clears outputs and shadow registers, and discards the run.
- Simultaneous wb_en and check on the same register: the checked value is the new wb_data.

## Structure
- Package frankie_mon_pkg holds the state enum (IDLE/RUN/DONE) and the checkpoint entry struct {cycle, reg, value}.
- Sub-module frankie_shadow_regs: parametrised register file with one write port, one read port and the forwarding mux.
- The table is a register array in the top level; no memory macro.

## Test plan
- Add program with checkpoints (cycle 2, mary, 2), (6, mary, 7), (9, shelley, 5), (13, mary, 12). Expected: done at cycle 14, pass=1.
- Same run with the last entry expecting 13. Expected: pass=0, fail_idx=3, fail_value=12, cycle_count=13.
- Checkpoint at cycle 5000 with MAX_CYCLES=4096. Expected: timeout=1 and done one edge after cycle_count reaches 4096.
- Write to reg 1 of 0x7FFF in the same cycle as the check of (cycle 4, reg 1, 0x7FFF). Expected: pass via forwarding.
- Two entries at cycle 3 (mary=10, sp=0). Expected: second entry checked at cycle 4 (catch-up); pass=1.
- reset low at cycle 7 of a run. Expected: IDLE, all outputs 0; a fresh start then runs and passes.
